// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a rotating priority pointer and a
// bounded hold time, so one requester cannot keep the resource while others wait.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       found;
  logic       any_req;
  logic       owner_req;
  logic       others_req;
  logic       keep_grant;

  // First asserted request found scanning upward from ptr, wrapping 3 -> 0.
  always_comb begin
    winner   = ptr;
    found    = 1'b0;
    scan_idx = ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req    = |req;
  assign owner_req  = req[gnt_idx];
  assign others_req = |(req & ~gnt);
  assign keep_grant = owner_req && (!others_req || (hold_cnt < HOLD_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= 4'b0001 << winner;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            ptr       <= winner + 2'd1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (keep_grant) begin
            if (hold_cnt < HOLD_LAST)
              hold_cnt <= hold_cnt + 1'b1;
          end else if (any_req) begin
            // Timeout or handoff: ptr already sits past the owner, so on a
            // timeout the current owner is scanned last and cannot win again.
            gnt       <= 4'b0001 << winner;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            ptr       <= winner + 2'd1;
          end else begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: a tenure-counting reference model queues
// expected grants, and an independent monitor compares them and checks invariants.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [6:0] exp_q[$];

  int m_owner;
  int m_ptr;
  int m_tenure;
  bit m_busy;
  int wait_cnt[4];

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int find_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = 0;
    m_ptr    = 0;
    m_tenure = 0;
    m_busy   = 1'b0;
  endtask

  // m_tenure counts how many cycles the current owner has held the grant.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] one_hot;
    logic [3:0] others;
    int w;
    one_hot = 4'b0001;
    one_hot = one_hot << m_owner;
    others  = r & ~one_hot;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        w = find_winner(r, m_ptr);
        m_owner = w; m_tenure = 1; m_ptr = (w + 1) % 4; m_busy = 1'b1;
      end
    end else if (r[m_owner] && (others == 4'b0000 || m_tenure < MAX_HOLD)) begin
      m_tenure++;
    end else if (r == 4'b0000) begin
      m_busy = 1'b0;
    end else begin
      w = find_winner(r, m_ptr);
      m_owner = w; m_tenure = 1; m_ptr = (w + 1) % 4;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r);
    logic [3:0] e_gnt;
    @(negedge clk);
    req = r;
    model_step(r);
    e_gnt = 4'b0001;
    e_gnt = m_busy ? (e_gnt << m_owner) : 4'b0000;
    exp_q.push_back({m_busy, 2'(m_owner), e_gnt});
  endtask

  // Monitor: invariants, starvation bound and scoreboard comparison each cycle.
  initial begin
    logic [6:0] e;
    logic [3:0] idx_hot;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end else begin
        check_output("onehot0", 8'($onehot0(gnt)), 8'd1);
        check_output("valid_vs_gnt", 8'(gnt_valid), 8'(|gnt));
        if (gnt_valid) begin
          idx_hot = 4'b0001;
          idx_hot = idx_hot << gnt_idx;
          check_output("gnt_vs_idx", 8'(gnt), 8'(idx_hot));
        end
        for (int i = 0; i < 4; i++) begin
          if (gnt[i] || !req[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
          if (wait_cnt[i] > 3 * MAX_HOLD)
            check_output($sformatf("starve_%0d", i), 8'(wait_cnt[i]), 8'(3 * MAX_HOLD));
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("gnt", 8'(gnt), 8'(e[3:0]));
          check_output("gnt_idx", 8'(gnt_idx), 8'(e[5:4]));
          check_output("gnt_valid", 8'(gnt_valid), 8'(e[6]));
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    req   = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_gnt", 8'(gnt), 8'h0);
    check_output("reset_idx", 8'(gnt_idx), 8'h0);
    check_output("reset_valid", 8'(gnt_valid), 8'h0);
    rst_n = 1'b1;

    // Single requester grant and release; index must stay at 2 after release.
    repeat (3) apply_stimulus(4'b0100);
    repeat (2) apply_stimulus(4'b0000);
    @(posedge clk); #2;
    check_output("idle_keeps_idx", 8'(gnt_idx), 8'd2);

    // All requesting; each owner drops after two cycles of tenure.
    for (int c = 0; c < 20; c++) begin
      r = 4'b1111;
      if (m_busy && m_tenure >= 2) r[m_owner] = 1'b0;
      apply_stimulus(r);
    end
    repeat (2) apply_stimulus(4'b0000);

    // Two constant requesters alternate on hold timeout.
    repeat (40) apply_stimulus(4'b0011);
    apply_stimulus(4'b0000);

    // Lone requester keeps the grant indefinitely.
    repeat (20) apply_stimulus(4'b1000);
    repeat (2) apply_stimulus(4'b0000);

    // Asynchronous reset while owner 1 holds the grant.
    apply_stimulus(4'b0010);
    repeat (3) apply_stimulus(4'b0110);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_gnt", 8'(gnt), 8'h0);
    check_output("async_rst_idx", 8'(gnt_idx), 8'h0);
    check_output("async_rst_valid", 8'(gnt_valid), 8'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b0110);
    @(posedge clk); #2;
    check_output("post_rst_gnt", 8'(gnt), 8'b0010);

    // Random requests with occasional per-bit toggles so requesters persist.
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      apply_stimulus(r);
    end
    repeat (3) apply_stimulus(4'b0000);
    @(posedge clk); #2;
    check_output("queue_drain", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
